fingerprint_recorder: RTL and testbench

Captures a contiguous window of `CAPTURE_LENGTH` unsigned samples from the sample stream, computes the window mean, and writes the mean-removed, saturated signed samples into the fingerprint buffer of a matched filter through its write port. It is the writer side of the fingerprint buffer: the matched filter reads fingerprints, and this block records them on a `start` command so new templates can be learned at run time instead of loaded from a memory file.

---
 rtl/fingerprint_recorder.sv | 162 ++++++++++++++++
 tb/tb_fingerprint_recorder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fingerprint_recorder.sv
// Records a contiguous window of unsigned samples, removes the window mean and
// streams the saturated signed result into a matched filter's fingerprint buffer.
module fingerprint_recorder #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0]        axiid,
  output logic [$clog2(CAPTURE_LENGTH)-1:0]   wr_addr,
  output logic signed [SAMPLE_DATA_WIDTH-1:0] wr_data,
  output logic                                wr_en,
  output logic                                busy,
  output logic                                done,
  output logic [SAMPLE_DATA_WIDTH-1:0]        mean_out
);

  localparam int W         = SAMPLE_DATA_WIDTH;
  localparam int N         = CAPTURE_LENGTH;
  localparam int AW        = $clog2(N);
  localparam int SUM_WIDTH = $clog2(N * ((1 << W) - 1) + 1);

  localparam logic [AW-1:0]        LAST_IDX = AW'(N - 1);
  localparam logic [SUM_WIDTH-1:0] N_DIV    = SUM_WIDTH'(N);
  localparam logic signed [W:0]    SAT_MAX  = (W + 1)'((1 << (W - 1)) - 1);
  localparam logic signed [W:0]    SAT_MIN  = -((W + 1)'(1 << (W - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MEAN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        cap_idx;
  logic [SUM_WIDTH-1:0] sum_q;
  logic [W-1:0]         mem [N];
  logic [W-1:0]         rd_data;
  logic [AW-1:0]        rd_addr;
  logic [AW-1:0]        rd_addr_q;
  logic                 rd_fin;
  logic                 rd_vld;
  logic                 issue;
  logic signed [W:0]    diff;
  logic signed [W-1:0]  sat_data;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (axiiv && cap_idx == LAST_IDX) state_d = S_MEAN;
      S_MEAN: begin
        issue   = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        issue = !rd_fin;
        // Leave once the final write is on the port.
        if (wr_en && wr_addr == LAST_IDX) state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Capture: index and running sum; any gap restarts the window
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_idx <= '0;
      sum_q   <= '0;
    end else if (state_q == S_CAPTURE) begin
      if (axiiv) begin
        cap_idx <= (cap_idx == LAST_IDX) ? '0 : cap_idx + 1'b1;
        sum_q   <= sum_q + SUM_WIDTH'(axiid);
      end else begin
        cap_idx <= '0;
        sum_q   <= '0;
      end
    end else if (state_q == S_IDLE) begin
      cap_idx <= '0;
      sum_q   <= '0;
    end
  end

  // NOTE: the sample RAM has no reset; its contents are only read after a full
  // contiguous window has overwritten every location.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE && axiiv) mem[cap_idx] <= axiid;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  mean_out <= '0;
    else if (state_q == S_MEAN) mean_out <= W'(sum_q / N_DIV);
  end

  // ---------------------------------------------------------------------------
  // Read-back: first read issues in MEAN so data meets the fresh mean
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr   <= '0;
      rd_fin    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_vld    <= issue;
      rd_addr_q <= rd_addr;
      if (state_q == S_IDLE) begin
        rd_addr <= '0;
        rd_fin  <= 1'b0;
      end else if (issue) begin
        if (rd_addr == LAST_IDX) rd_fin  <= 1'b1;
        else                     rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  always_comb begin
    diff = $signed({1'b0, rd_data}) - $signed({1'b0, mean_out});
    if (diff > SAT_MAX)      sat_data = SAT_MAX[W-1:0];
    else if (diff < SAT_MIN) sat_data = SAT_MIN[W-1:0];
    else                     sat_data = diff[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= rd_vld;
      if (rd_vld) begin
        wr_addr <= rd_addr_q;
        wr_data <= sat_data;
      end
    end
  end

endmodule

// File: tb/tb_fingerprint_recorder.sv
// Directed bench for fingerprint_recorder with N=8, W=8: mean, saturation,
// gap restart, ignored start pulses, cycle timing and asynchronous reset.
`timescale 1ns/1ps
module tb_fingerprint_recorder;

  localparam int W = 8;
  localparam int N = 8;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic              axiiv = 1'b0;
  logic [W-1:0]      axiid = '0;
  logic [2:0]        wr_addr;
  logic signed [W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic [W-1:0]      mean_out;

  fingerprint_recorder #(
    .SAMPLE_DATA_WIDTH(W),
    .CAPTURE_LENGTH   (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .axiiv   (axiiv),
    .axiid   (axiid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .busy    (busy),
    .done    (done),
    .mean_out(mean_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor sampled on the falling edge.
  int                  n_wr, first_wr_cyc, last_wr_cyc, n_done, done_cyc, last_busy_cyc;
  logic [2:0]          mon_addr [16];
  logic signed [W-1:0] mon_data [16];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (n_wr < 16) begin
        mon_addr[n_wr] = wr_addr;
        mon_data[n_wr] = wr_data;
      end
      if (n_wr == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_wr++;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) last_busy_cyc = cyc;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_wr          = 0;
    n_done        = 0;
    first_wr_cyc  = -1;
    last_wr_cyc   = -1;
    done_cyc      = -1;
    last_busy_cyc = -1;
  endtask

  logic [W-1:0] beats [N];
  int           exp_d [N];
  int           exp_mean;
  int           prev_mean = 0;

  task automatic run_scenario(input string name, input bit gap, input bit hazard);
    int last_c;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, " busy after start"}, busy, 1);
    check({name, " mean_out held"}, mean_out, prev_mean);
    if (gap) begin
      for (int i = 0; i < 5; i++) begin
        axiiv = 1'b1;
        axiid = 8'd50;
        tick();
      end
      axiiv = 1'b0;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      axiiv = 1'b1;
      axiid = beats[i];
      if (hazard && i == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    axiiv  = 1'b0;
    axiid  = 8'hAA;
    last_c = cyc;
    if (hazard) begin
      for (int k = 0; k < 4; k++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < 40 && n_done == 0; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    check({name, " done count"}, n_done, 1);
    check({name, " write count"}, n_wr, N);
    check({name, " mean_out"}, mean_out, exp_mean);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s addr[%0d]", name, i), mon_addr[i], i);
      check($sformatf("%s data[%0d]", name, i), mon_data[i], exp_d[i]);
    end
    check({name, " first write cycle"}, first_wr_cyc - last_c, 2);
    check({name, " last write cycle"}, last_wr_cyc - last_c, N + 1);
    check({name, " done cycle"}, done_cyc - last_c, N + 2);
    check({name, " last busy cycle"}, last_busy_cyc - last_c, N + 2);
    check({name, " idle after"}, busy, 0);
    prev_mean = exp_mean;
  endtask

  initial begin
    bit found;
    clear_mon();

    // Reset held for three cycles.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset wr_en", wr_en, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mean_out", mean_out, 0);
    tick();
    tick();
    check("idle busy before start", busy, 0);

    beats    = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_d    = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_mean = 100;
    run_scenario("const", 1'b0, 1'b0);

    beats    = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_d    = '{-3, -2, -1, 0, 1, 2, 3, 4};
    exp_mean = 3;
    run_scenario("ramp", 1'b0, 1'b0);

    beats    = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_d    = '{127, -31, -31, -31, -31, -31, -31, -31};
    exp_mean = 31;
    run_scenario("sat_hi", 1'b0, 1'b0);

    beats    = '{8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    exp_d    = '{-128, 32, 32, 32, 32, 32, 32, 32};
    exp_mean = 223;
    run_scenario("sat_lo", 1'b0, 1'b0);

    beats    = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_d    = '{-3, -2, -1, 0, 1, 2, 3, 4};
    exp_mean = 3;
    run_scenario("gap", 1'b1, 1'b0);
    run_scenario("hazard", 1'b0, 1'b1);

    // Asynchronous reset during the fourth write cycle.
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      axiiv = 1'b1;
      axiid = 8'd7;
      tick();
    end
    axiiv = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (wr_en === 1'b1 && wr_addr === 3'd3) found = 1'b1;
    end
    check("rst reached fourth write", found, 1);
    #1 rst = 1'b0;
    #1;
    check("rst wr_en", wr_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst wr_data", wr_data, 0);
    check("rst mean_out", mean_out, 0);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("rst write count", n_wr, 3);
    check("rst no done", n_done, 0);
    check("rst idle", busy, 0);
    check("rst wr_en stays low", wr_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
